// File: rtl/bw_ictag_plru_pkg.sv
// Shared constants and FSM state type for the I-cache tag store.
// Defaults match the fetch-stage I-cache geometry.
package bw_ictag_plru_pkg;

   localparam int ICT_WAYS  = 4;
   localparam int ICT_LINES = 128;
   localparam int ICT_AWID  = 32;
   localparam int ICT_LOBIT = 6;

   typedef enum logic {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } ict_state_t;

endpackage

// File: rtl/bw_plru_tree.sv
// Tree pseudo-LRU for one set: combinational victim walk and next-state after a touch.
// Zero latency, no flow control; only instantiated for WAYS >= 2.
module bw_plru_tree #(
   parameter int WAYS = 4,
   parameter int LW   = $clog2(WAYS)
) (
   input  logic [WAYS-2:0] bits,
   input  logic [LW-1:0]   way,
   input  logic            touch,
   output logic [LW-1:0]   victim,
   output logic [WAYS-2:0] nxt
);

   // Heap layout: node n lives at heap[n], root is 1, leaves are WAYS..2*WAYS-1.
   logic [2*WAYS-1:0] heap;
   logic [LW:0]       node;

   always_comb begin
      heap = {{WAYS{1'b0}}, bits, 1'b0};
      node = (LW+1)'(1);
      for (int l = 0; l < LW; l++) begin
         node = {node[LW-1:0], heap[node]};
      end
      victim = node[LW-1:0];
   end

   // A node on the touched way's path is pointed at the opposite half.
   for (genvar n = 1; n < WAYS; n++) begin : g_node
      localparam int L = $clog2(n + 1) - 1;
      logic [LW:0] anc;
      assign anc = {1'b1, way} >> (LW - L);
      assign nxt[n-1] = (touch && anc == (LW+1)'(n)) ? ~way[LW-1-L] : bits[n-1];
   end

endmodule

// File: rtl/bw_ictag_plru.sv
// I-cache tag store: set-assoc tags/valids, registered lookup index, PLRU victim, line/whole invalidate.
// Hit one cycle after rd_en; wr/inv_line dropped and hits forced low while rdy=0 (sweep).
module bw_ictag_plru
   import bw_ictag_plru_pkg::*;
#(
   parameter int WAYS  = ICT_WAYS,
   parameter int LINES = ICT_LINES,
   parameter int AWID  = ICT_AWID,
   parameter int LOBIT = ICT_LOBIT,
   parameter int WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            evn,
   input  logic            rd_en,
   input  logic [AWID-1:0] rd_ip,
   output logic            hit,
   output logic [WW-1:0]   hit_way,
   output logic [WW-1:0]   victim_way,
   input  logic            wr,
   input  logic [AWID-1:0] wr_ip,
   input  logic [WW-1:0]   wr_way,
   input  logic            inv_line,
   input  logic [AWID-1:0] inv_ip,
   input  logic            inv_all,
   output logic            rdy
);

   localparam int IDXW = $clog2(LINES);
   localparam int TAGW = AWID - LOBIT - IDXW;

   logic [TAGW-1:0] tag_mem [WAYS][LINES];
   logic [WAYS-1:0] val_mem [LINES];

   ict_state_t      state;
   logic [IDXW-1:0] cnt;
   logic [IDXW-1:0] ridx;
   logic [TAGW-1:0] rtag;
   logic            ren;

   logic [IDXW-1:0] rd_idx, widx, iidx;
   logic [TAGW-1:0] wtag, itag;
   logic [WAYS-1:0] match, inv_hit;
   logic            wr_ok;
   logic            unused_lo;

   assign unused_lo = ^{rd_ip[LOBIT-1:0], wr_ip[LOBIT-1:0], inv_ip[LOBIT-1:0]};

   // The even bank of a fetch pair reads the following set; the add wraps naturally.
   assign rd_idx = rd_ip[LOBIT +: IDXW] + IDXW'(evn & rd_ip[LOBIT]);
   assign widx   = wr_ip[LOBIT +: IDXW];
   assign wtag   = wr_ip[AWID-1 -: TAGW];
   assign iidx   = inv_ip[LOBIT +: IDXW];
   assign itag   = inv_ip[AWID-1 -: TAGW];

   assign rdy   = (state == IDLE);
   assign wr_ok = wr & rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SWEEP;
         cnt   <= '0;
         ridx  <= '0;
         rtag  <= '0;
         ren   <= 1'b0;
      end else begin
         ren  <= rd_en;
         ridx <= rd_idx;
         rtag <= rd_ip[AWID-1 -: TAGW];
         case (state)
            SWEEP: begin
               if (inv_all) begin
                  cnt <= '0;
               end else if (cnt == IDXW'(LINES - 1)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (inv_all) begin
                  state <= SWEEP;
                  cnt   <= '0;
               end
            end
            default: state <= SWEEP;
         endcase
      end
   end

   // inv_line also catches the line being filled on the same edge, so it wins over wr.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         inv_hit[w] = (tag_mem[w][iidx] == itag) ||
                      (wr && wr_way == WW'(w) && widx == iidx && wtag == itag);
      end
   end

   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         val_mem[cnt] <= '0;
      end else begin
         if (wr) begin
            tag_mem[wr_way][widx] <= wtag;
            val_mem[widx][wr_way] <= 1'b1;
         end
         if (inv_line) begin
            for (int w = 0; w < WAYS; w++) begin
               if (inv_hit[w]) val_mem[iidx][w] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         match[w] = val_mem[ridx][w] && (tag_mem[w][ridx] == rtag);
      end
   end

   assign hit = ren && rdy && (|match);

   always_comb begin
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit && match[w]) hit_way = WW'(w);
      end
   end

   if (WAYS > 1) begin : g_plru
      logic [WAYS-2:0] plru [LINES];
      logic [WAYS-2:0] hit_nxt, wr_base, wr_nxt;
      logic [WW-1:0]   unused_wr_victim;

      bw_plru_tree #(.WAYS(WAYS)) u_rd (
         .bits   (plru[ridx]),
         .way    (hit_way),
         .touch  (hit),
         .victim (victim_way),
         .nxt    (hit_nxt)
      );

      // The fill touch lands after the hit touch when both hit the same set.
      assign wr_base = (hit && ridx == widx) ? hit_nxt : plru[widx];

      bw_plru_tree #(.WAYS(WAYS)) u_wr (
         .bits   (wr_base),
         .way    (wr_way),
         .touch  (wr_ok),
         .victim (unused_wr_victim),
         .nxt    (wr_nxt)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int l = 0; l < LINES; l++) plru[l] <= '0;
         end else if (state == SWEEP) begin
            plru[cnt] <= '0;
         end else begin
            if (hit)   plru[ridx] <= hit_nxt;
            if (wr_ok) plru[widx] <= wr_nxt;
         end
      end
   end else begin : g_noplru
      assign victim_way = '0;
   end

endmodule

// File: tb/tb_bw_ictag_plru.sv
// Bench for bw_ictag_plru: directed cases plus random traffic against a set/way/recency model.
module tb_bw_ictag_plru;

   localparam int WAYS  = 4;
   localparam int LINES = 128;
   localparam int LW    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        evn, rd_en, wr, inv_line, inv_all;
   logic [31:0] rd_ip, wr_ip, inv_ip;
   logic [1:0]  wr_way;
   logic        hit, rdy;
   logic [1:0]  hit_way, victim_way;

   always #5 clk = ~clk;

   bw_ictag_plru dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .evn        (evn),
      .rd_en      (rd_en),
      .rd_ip      (rd_ip),
      .hit        (hit),
      .hit_way    (hit_way),
      .victim_way (victim_way),
      .wr         (wr),
      .wr_ip      (wr_ip),
      .wr_way     (wr_way),
      .inv_line   (inv_line),
      .inv_ip     (inv_ip),
      .inv_all    (inv_all),
      .rdy        (rdy)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: per-set tag/valid tables and, for every subtree, which half was used last.
   int  m_tag [WAYS][LINES];
   bit  m_val [WAYS][LINES];
   bit  m_mru [LINES][WAYS];
   bit  m_rdy;
   int  m_cnt, m_ridx, m_rtag;
   bit  m_ren;

   function automatic int idx_of(input logic [31:0] ip, input bit e);
      int s;
      s = int'((ip >> 6) & 32'h7f);
      if (e) s += int'((ip >> 6) & 32'h1);
      return s % LINES;
   endfunction

   function automatic int tag_of(input logic [31:0] ip);
      return int'(ip >> 13);
   endfunction

   function automatic void set_fresh(input int s);
      for (int n = 0; n < WAYS; n++) m_mru[s][n] = 1'b1;
   endfunction

   function automatic void m_touch(input int s, input int w);
      for (int l = 0; l < LW; l++) m_mru[s][(1 << l) + (w >> (LW - l))] = bit'((w >> (LW - l - 1)) & 1);
   endfunction

   function automatic int m_victim(input int s);
      int p = 0;
      for (int l = 0; l < LW; l++) p = p * 2 + (m_mru[s][(1 << l) + p] ? 0 : 1);
      return p;
   endfunction

   function automatic void exp_look(output bit h, output int hw);
      h = 0;
      hw = 0;
      if (m_ren && m_rdy) begin
         for (int w = 0; w < WAYS; w++) begin
            if (!h && m_val[w][m_ridx] && m_tag[w][m_ridx] == m_rtag) begin
               h = 1;
               hw = w;
            end
         end
      end
   endfunction

   function automatic void model_reset();
      m_rdy = 0; m_cnt = 0; m_ren = 0; m_ridx = 0; m_rtag = 0;
      for (int s = 0; s < LINES; s++) set_fresh(s);
   endfunction

   task automatic check_outputs();
      bit h;
      int hw;
      exp_look(h, hw);
      chk("rdy", 32'(rdy), 32'(m_rdy));
      chk("hit", 32'(hit), 32'(h));
      chk("hit_way", 32'(hit_way), hw);
      chk("victim_way", 32'(victim_way), m_victim(m_ridx));
   endtask

   task automatic tick();
      bit h;
      int hw, wi, ii;
      bit clr [WAYS];
      exp_look(h, hw);
      @(posedge clk);
      if (!m_rdy) begin
         for (int w = 0; w < WAYS; w++) m_val[w][m_cnt] = 0;
         set_fresh(m_cnt);
         if (inv_all) m_cnt = 0;
         else if (m_cnt == LINES - 1) begin m_rdy = 1; m_cnt = 0; end
         else m_cnt++;
      end else begin
         wi = idx_of(wr_ip, 0);
         ii = idx_of(inv_ip, 0);
         if (h) m_touch(m_ridx, hw);
         if (wr) m_touch(wi, int'(wr_way));
         // Invalidate removes the address whether it was present before or after the fill.
         for (int w = 0; w < WAYS; w++) clr[w] = inv_line && m_tag[w][ii] == tag_of(inv_ip);
         if (wr) begin
            m_tag[wr_way][wi] = tag_of(wr_ip);
            m_val[wr_way][wi] = 1;
         end
         for (int w = 0; w < WAYS; w++)
            if (clr[w] || (inv_line && m_tag[w][ii] == tag_of(inv_ip))) m_val[w][ii] = 0;
         if (inv_all) begin m_rdy = 0; m_cnt = 0; end
      end
      m_ren  = rd_en;
      m_ridx = idx_of(rd_ip, evn);
      m_rtag = tag_of(rd_ip);
      #1;
      check_outputs();
   endtask

   task automatic set_idle();
      rd_en = 0; wr = 0; inv_line = 0; inv_all = 0;
   endtask

   task automatic do_fill(input logic [31:0] a, input int w);
      set_idle();
      wr = 1; wr_ip = a; wr_way = 2'(w);
      tick();
      wr = 0;
   endtask

   task automatic do_look(input logic [31:0] a, input bit e);
      set_idle();
      rd_en = 1; rd_ip = a; evn = e;
      tick();
      rd_en = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      int sets [7] = '{0, 1, 5, 65, 66, 126, 127};
      logic [31:0] t, s, lo;
      t  = 32'($urandom_range(0, 3));
      s  = 32'(sets[$urandom_range(0, 6)]);
      lo = 32'($urandom_range(0, 63));
      return (t << 13) | (s << 6) | lo;
   endfunction

   task automatic do_reset();
      set_idle();
      rst_n = 0;
      repeat (3) @(posedge clk);
      model_reset();
      #1;
      chk("rst_rdy", 32'(rdy), 0);
      chk("rst_hit", 32'(hit), 0);
      chk("rst_hit_way", 32'(hit_way), 0);
      chk("rst_victim", 32'(victim_way), 0);
      rst_n = 1;
   endtask

   task automatic sweep_with_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         rd_en = 1; rd_ip = rand_addr(); evn = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1)); wr_ip = rand_addr(); wr_way = 2'($urandom_range(0, 3));
         tick();
      end
      set_idle();
   endtask

   initial begin
      int lowc;
      bit restarted;
      evn = 0; rd_ip = 0; wr_ip = 0; inv_ip = 0; wr_way = 0;
      do_reset();

      // Sweep after reset takes exactly LINES cycles; lookups miss throughout.
      sweep_with_traffic(LINES - 1);
      chk("rdy_sweep_end", 32'(rdy), 0);
      sweep_with_traffic(1);
      chk("rdy_up", 32'(rdy), 1);

      do_fill(32'h0000_1040, 2);
      do_look(32'h0000_1044, 0);
      chk("fill_hit", 32'(hit), 1);
      chk("fill_hit_way", 32'(hit_way), 2);

      do_fill(32'h0000_1080, 1);
      do_fill(32'h0000_0000, 3);
      do_look(32'h0000_1040, 1);
      chk("evn_hit", 32'(hit), 1);
      chk("evn_hit_way", 32'(hit_way), 1);
      do_look(32'h0000_1FC0, 1);
      chk("evn_wrap_hit", 32'(hit), 1);
      chk("evn_wrap_way", 32'(hit_way), 3);

      do_fill(32'h0000_0140, 0);
      do_fill(32'h0000_2140, 1);
      do_fill(32'h0000_4140, 2);
      do_fill(32'h0000_6140, 3);
      do_look(32'h0000_0140, 0);
      chk("plru_victim0", 32'(victim_way), 0);
      chk("plru_hit_way0", 32'(hit_way), 0);
      do_look(32'h0000_8140, 0);
      chk("plru_miss", 32'(hit), 0);
      chk("plru_victim2", 32'(victim_way), 2);

      set_idle();
      wr = 1; wr_ip = 32'h0000_1040; wr_way = 2;
      inv_line = 1; inv_ip = 32'h0000_1040;
      tick();
      do_look(32'h0000_1040, 0);
      chk("inv_wins", 32'(hit), 0);
      set_idle();
      inv_line = 1; inv_ip = 32'h0000_3080;
      tick();
      do_look(32'h0000_1080, 0);
      chk("inv_other_tag_hit", 32'(hit), 1);
      chk("inv_other_tag_way", 32'(hit_way), 1);

      for (int i = 0; i < 3000; i++) begin
         rd_en    = ($urandom_range(0, 9) < 7);
         rd_ip    = rand_addr();
         evn      = 1'($urandom_range(0, 1));
         wr       = ($urandom_range(0, 3) == 0);
         wr_ip    = rand_addr();
         wr_way   = 2'($urandom_range(0, 3));
         inv_line = ($urandom_range(0, 9) == 0);
         inv_ip   = rand_addr();
         inv_all  = ($urandom_range(0, 499) == 0);
         tick();
      end
      set_idle();

      for (int i = 0; i < 300 && !m_rdy; i++) tick();
      chk("idle_before_inv_all", 32'(rdy), 1);

      // A restart when cnt reaches 60 (61 cycles into the sweep) adds a full LINES sweep.
      inv_all = 1;
      tick();
      inv_all = 0;
      lowc = (rdy === 1'b0) ? 1 : 0;
      restarted = 0;
      for (int i = 0; i < 400 && rdy !== 1'b1; i++) begin
         rd_en = 1; rd_ip = rand_addr(); evn = 1'($urandom_range(0, 1));
         inv_all = (!restarted && m_cnt == 60);
         if (inv_all) restarted = 1;
         tick();
         inv_all = 0;
         if (rdy === 1'b0) lowc++;
      end
      set_idle();
      chk("restart_sweep_len", lowc, 61 + LINES);
      do_look(32'h0000_1080, 0);
      chk("miss_after_sweep", 32'(hit), 0);

      // Reset in the middle of a sweep starts a fresh one.
      inv_all = 1;
      tick();
      inv_all = 0;
      sweep_with_traffic(20);
      do_reset();
      sweep_with_traffic(LINES);
      chk("rdy_after_midsweep_reset", 32'(rdy), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
